memory_writeback: RTL and testbench
===================================

Name: memory_writeback

Overview:
- Downstream neighbour of the execute stage. Consumes the registered M-stage bundle: regwriteM, resultsrcM, memwriteM, aluresultM, writedataM, RdM, pcplus4M.
- Holds the word-addressed data memory and performs loads and stores.
- Registers the M/W pipeline boundary and drives resultW, the writeback value. resultW feeds both the register file and the execute-stage forwarding muxes.
- Also exports regwriteW/RdW for the hazard unit.

Parameters:
DEPTH, 64, number of 32-bit words in data memory
ADDR_W, 6, word-index width; must satisfy 2**ADDR_W >= DEPTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
regwriteM  input  1  register-file write enable, M stage
resultsrcM  input  2  writeback select, M stage
memwriteM  input  1  store enable
aluresultM  input  32  byte address for load/store; also the ALU result
writedataM  input  32  store data
RdM  input  5  destination register, M stage
pcplus4M  input  32  return address, M stage
readdataM  output  32  combinational memory read data
regwriteW  output  1  registered regwriteM
RdW  output  5  registered RdM
resultsrcW  output  2  registered resultsrcM
memerrW  output  1  registered out-of-range access flag
resultW  output  32  writeback value

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous, active-high. All W-stage registers clear immediately on rst=1 and hold cleared while rst=1.
- Reset values: regwriteW=0, RdW=0, resultsrcW=00, memerrW=0, aluresultW=0, readdataW=0, pcplus4W=0. Hence resultW=0 during reset.
- Memory contents are not affected by reset.
- Addressing:
  - Word access only.
  - idx = aluresultM[31:2]; aluresultM[1:0] is ignored (no misalignment trap).
  - In range means idx < DEPTH, compared over the full 30-bit index. There is no wrap-around: address 4*DEPTH is out of range, not word 0.
- Read: combinational. readdataM = mem[idx] when in range, else 32'h0. Reads occur every cycle regardless of memwriteM.
- Write: on rising clk, if memwriteM=1, rst=0 and in range, mem[idx] <= writedataM.
  - Out-of-range store: memory unchanged.
  - Stores are blocked while rst=1.
- Read-during-write, same cycle and same index: readdataM and the captured readdataW return the OLD word. The new word is visible from the next cycle, so a load issued in the cycle after a store sees the stored data.
- memerr:
  - memerr_next = (memwriteM | resultsrcM==01) & out-of-range.
  - ALU-only or jump instructions never flag.
- M/W register: on every rising clk with rst=0, captures regwriteM, RdM, resultsrcM, aluresultM, readdataM, pcplus4M and memerr_next.
  - There is no enable or flush; bubbles arrive as regwriteM=0, memwriteM=0.
- Writeback mux, combinational from W registers:
  - resultsrcW=00 -> aluresultW
  - 01 -> readdataW
  - 10 -> pcplus4W
  - 11 -> 32'h0
- Latency: M inputs to resultW/regwriteW/RdW is exactly 1 cycle. Store to memory update is 1 edge.
- RdW=0 is passed through unchanged; suppressing writes to x0 is the register file's job.
- Reset mid-operation:
  - rst asserting in the same cycle as a store blocks that store.
  - W registers clear asynchronously, without waiting for a clock edge.
  - After rst deasserts, the first edge captures normally.

Test Plan:
- Reset: hold rst=1 with arbitrary M inputs and toggling clk -> regwriteW=0, RdW=0, resultsrcW=00, memerrW=0, resultW=0 throughout. Assert rst asynchronously mid-cycle -> outputs clear before the next edge.
- Store then load: cycle0 memwriteM=1, aluresultM=0x10, writedataM=0xDEADBEEF; cycle1 resultsrcM=01, aluresultM=0x13, RdM=5, regwriteM=1 -> after edge 2, resultW=0xDEADBEEF, RdW=5, regwriteW=1.
- Read-during-write: mem[4] preloaded 0x11111111; in one cycle apply memwriteM=1, aluresultM=0x10, writedataM=0x22222222, resultsrcM=01 -> readdataM=0x11111111, resultW after the edge=0x11111111; a load of 0x10 in the next cycle returns 0x22222222.
- Writeback select, one cycle each with aluresultM=0x55, pcplus4M=0x104, mem word=0x77:
  - resultsrcM=00 -> resultW=0x55
  - 10 -> 0x104
  - 11 -> 0x0
- Out of range (DEPTH=64): store to 0x100 with writedataM=0xAAAA -> memerrW=1 next cycle, mem[0] unchanged; load from 0x100 -> resultW=0, memerrW=1; ALU op with aluresultM=0x100 and resultsrcM=00 -> memerrW=0.
- Reset during store: memwriteM=1, aluresultM=0x20, writedataM=0x1234 with rst=1 across the edge -> after release, a load of 0x20 returns the prior contents, not 0x1234.

Source files
------------

// File: rtl/memory_writeback_if.sv
// rtl/memory_writeback_if.sv - M-stage inputs and W-stage outputs of the memory/writeback stage
interface memory_writeback_if;
  logic        regwriteM;
  logic [1:0]  resultsrcM;
  logic        memwriteM;
  logic [31:0] aluresultM;
  logic [31:0] writedataM;
  logic [4:0]  RdM;
  logic [31:0] pcplus4M;
  logic [31:0] readdataM;
  logic        regwriteW;
  logic [4:0]  RdW;
  logic [1:0]  resultsrcW;
  logic        memerrW;
  logic [31:0] resultW;

  modport master (
    output regwriteM, resultsrcM, memwriteM, aluresultM, writedataM, RdM, pcplus4M,
    input  readdataM, regwriteW, RdW, resultsrcW, memerrW, resultW
  );

  modport slave (
    input  regwriteM, resultsrcM, memwriteM, aluresultM, writedataM, RdM, pcplus4M,
    output readdataM, regwriteW, RdW, resultsrcW, memerrW, resultW
  );
endinterface

// File: rtl/memory_writeback.sv
// rtl/memory_writeback.sv - word-addressed data memory, M/W pipeline register and writeback mux
module memory_writeback #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  memory_writeback_if.slave bus
);

  logic [31:0]       r_mem [DEPTH];

  logic [29:0]       w_idx;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_readdata;
  logic              w_memerr_next;
  logic [1:0]        w_unused;

  logic              r_regwriteW;
  logic [4:0]        r_RdW;
  logic [1:0]        r_resultsrcW;
  logic              r_memerrW;
  logic [31:0]       r_aluresultW;
  logic [31:0]       r_readdataW;
  logic [31:0]       r_pcplus4W;
  logic [31:0]       w_resultW;

  // Full 30-bit compare so addresses beyond the array never alias onto low words.
  assign w_idx      = bus.aluresultM[31:2];
  assign w_unused   = bus.aluresultM[1:0];
  assign w_in_range = (w_idx < 30'(DEPTH));
  assign w_addr     = w_idx[ADDR_W-1:0];

  assign w_readdata = w_in_range ? r_mem[w_addr] : 32'h0;

  assign w_memerr_next = (bus.memwriteM | (bus.resultsrcM == 2'b01)) & ~w_in_range;

  // Memory has no reset; rst only gates the write strobe.
  always_ff @(posedge clk) begin
    if (!rst && bus.memwriteM && w_in_range) begin
      r_mem[w_addr] <= bus.writedataM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regwriteW  <= 1'b0;
      r_RdW        <= 5'd0;
      r_resultsrcW <= 2'b00;
      r_memerrW    <= 1'b0;
      r_aluresultW <= 32'h0;
      r_readdataW  <= 32'h0;
      r_pcplus4W   <= 32'h0;
    end else begin
      r_regwriteW  <= bus.regwriteM;
      r_RdW        <= bus.RdM;
      r_resultsrcW <= bus.resultsrcM;
      r_memerrW    <= w_memerr_next;
      r_aluresultW <= bus.aluresultM;
      r_readdataW  <= w_readdata;
      r_pcplus4W   <= bus.pcplus4M;
    end
  end

  always_comb begin
    w_resultW = 32'h0;
    case (r_resultsrcW)
      2'b00:   w_resultW = r_aluresultW;
      2'b01:   w_resultW = r_readdataW;
      2'b10:   w_resultW = r_pcplus4W;
      default: w_resultW = 32'h0;
    endcase
  end

  assign bus.readdataM  = w_readdata;
  assign bus.regwriteW  = r_regwriteW;
  assign bus.RdW        = r_RdW;
  assign bus.resultsrcW = r_resultsrcW;
  assign bus.memerrW    = r_memerrW;
  assign bus.resultW    = w_resultW;

endmodule

// File: tb/tb_memory_writeback.sv
// tb/tb_memory_writeback.sv - directed vector bench for memory_writeback
module tb_memory_writeback;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  memory_writeback_if bus ();

  memory_writeback #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic        chk_rd;
    logic [31:0] e_rdm;
    logic [31:0] e_res;
    logic        e_rw;
    logic [4:0]  e_rd;
    logic [1:0]  e_rs;
    logic        e_err;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(logic rw, logic [1:0] rs, logic mw, logic [31:0] alu,
                              logic [31:0] wd, logic [4:0] rd, logic [31:0] pc4,
                              logic chk_rd, logic [31:0] e_rdm, logic [31:0] e_res,
                              logic e_err);
    vec_t v;
    v.rw = rw; v.rs = rs; v.mw = mw; v.alu = alu; v.wd = wd; v.rd = rd; v.pc4 = pc4;
    v.chk_rd = chk_rd; v.e_rdm = e_rdm; v.e_res = e_res;
    v.e_rw = rw; v.e_rd = rd; v.e_rs = rs; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic [1:0] rs, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] pc4);
    bus.regwriteM  = rw;
    bus.resultsrcM = rs;
    bus.memwriteM  = mw;
    bus.aluresultM = alu;
    bus.writedataM = wd;
    bus.RdM        = rd;
    bus.pcplus4M   = pc4;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, ".regwriteW"},  32'(bus.regwriteW),  32'h0);
    chk({tag, ".RdW"},        32'(bus.RdW),        32'h0);
    chk({tag, ".resultsrcW"}, 32'(bus.resultsrcW), 32'h0);
    chk({tag, ".memerrW"},    32'(bus.memerrW),    32'h0);
    chk({tag, ".resultW"},    bus.resultW,         32'h0);
  endtask

  task automatic bubble();
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //        rw    rs     mw    alu           wd            rd     pc4        chk   readdataM     resultW       err
    vecs[0]  = mk(1'b0, 2'b00, 1'b1, 32'h10,       32'hDEADBEEF, 5'd0, 32'h0,     1'b0, 32'h0,        32'h10,       1'b0);
    vecs[1]  = mk(1'b1, 2'b01, 1'b0, 32'h13,       32'h0,        5'd5, 32'h0,     1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    vecs[2]  = mk(1'b0, 2'b00, 1'b1, 32'h10,       32'h11111111, 5'd0, 32'h0,     1'b1, 32'hDEADBEEF, 32'h10,       1'b0);
    vecs[3]  = mk(1'b1, 2'b01, 1'b1, 32'h10,       32'h22222222, 5'd7, 32'h0,     1'b1, 32'h11111111, 32'h11111111, 1'b0);
    vecs[4]  = mk(1'b1, 2'b01, 1'b0, 32'h10,       32'h0,        5'd8, 32'h0,     1'b1, 32'h22222222, 32'h22222222, 1'b0);
    vecs[5]  = mk(1'b0, 2'b00, 1'b1, 32'h54,       32'h77,       5'd0, 32'h0,     1'b0, 32'h0,        32'h54,       1'b0);
    vecs[6]  = mk(1'b1, 2'b00, 1'b0, 32'h55,       32'h0,        5'd1, 32'h104,   1'b1, 32'h77,       32'h55,       1'b0);
    vecs[7]  = mk(1'b1, 2'b01, 1'b0, 32'h55,       32'h0,        5'd1, 32'h104,   1'b1, 32'h77,       32'h77,       1'b0);
    vecs[8]  = mk(1'b1, 2'b10, 1'b0, 32'h55,       32'h0,        5'd1, 32'h104,   1'b1, 32'h77,       32'h104,      1'b0);
    vecs[9]  = mk(1'b1, 2'b11, 1'b0, 32'h55,       32'h0,        5'd1, 32'h104,   1'b1, 32'h77,       32'h0,        1'b0);
    vecs[10] = mk(1'b0, 2'b00, 1'b1, 32'h0,        32'h0BADF00D, 5'd0, 32'h0,     1'b0, 32'h0,        32'h0,        1'b0);
    vecs[11] = mk(1'b0, 2'b00, 1'b1, 32'h100,      32'hAAAA,     5'd0, 32'h0,     1'b1, 32'h0,        32'h100,      1'b1);
    vecs[12] = mk(1'b1, 2'b01, 1'b0, 32'h0,        32'h0,        5'd2, 32'h0,     1'b1, 32'h0BADF00D, 32'h0BADF00D, 1'b0);
    vecs[13] = mk(1'b1, 2'b01, 1'b0, 32'h100,      32'h0,        5'd2, 32'h0,     1'b1, 32'h0,        32'h0,        1'b1);
    vecs[14] = mk(1'b1, 2'b00, 1'b0, 32'h100,      32'h0,        5'd3, 32'h0,     1'b1, 32'h0,        32'h100,      1'b0);
    vecs[15] = mk(1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0,        5'd1, 32'h200,   1'b1, 32'h0,        32'h200,      1'b0);
    vecs[16] = mk(1'b0, 2'b00, 1'b1, 32'hFC,       32'hCAFEF00D, 5'd0, 32'h0,     1'b0, 32'h0,        32'hFC,       1'b0);
    vecs[17] = mk(1'b1, 2'b01, 1'b0, 32'hFE,       32'h0,        5'd9, 32'h0,     1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
    vecs[18] = mk(1'b1, 2'b01, 1'b0, 32'hFFFFFFFC, 32'h0,        5'd4, 32'h0,     1'b1, 32'h0,        32'h0,        1'b1);

    // Reset held with arbitrary M inputs and a live clock.
    rst = 1'b1;
    drive(1'b1, 2'b10, 1'b1, 32'h40, 32'h99, 5'd31, 32'h1234);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_cleared("rst_hold");
    end
    rst = 1'b0;
    bubble();
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rw, vecs[i].rs, vecs[i].mw, vecs[i].alu, vecs[i].wd, vecs[i].rd, vecs[i].pc4);
      @(negedge clk);
      if (vecs[i].chk_rd) chk($sformatf("v%0d.readdataM", i), bus.readdataM, vecs[i].e_rdm);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.resultW", i),    bus.resultW,            vecs[i].e_res);
      chk($sformatf("v%0d.regwriteW", i),  32'(bus.regwriteW),     32'(vecs[i].e_rw));
      chk($sformatf("v%0d.RdW", i),        32'(bus.RdW),           32'(vecs[i].e_rd));
      chk($sformatf("v%0d.resultsrcW", i), 32'(bus.resultsrcW),    32'(vecs[i].e_rs));
      chk($sformatf("v%0d.memerrW", i),    32'(bus.memerrW),       32'(vecs[i].e_err));
    end

    // Asynchronous reset mid-cycle clears W outputs before the next edge.
    drive(1'b1, 2'b10, 1'b0, 32'h8, 32'h0, 5'd12, 32'h300);
    @(posedge clk);
    #1;
    chk("pre_async.resultW", bus.resultW, 32'h300);
    #2;
    rst = 1'b1;
    #1;
    chk_cleared("async_rst");
    #1;
    rst = 1'b0;

    // Store blocked by reset across the edge; prior word survives.
    drive(1'b0, 2'b00, 1'b1, 32'h20, 32'h5555, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 2'b00, 1'b1, 32'h20, 32'h1234, 5'd0, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_cleared("rst_store");
    rst = 1'b0;
    drive(1'b1, 2'b01, 1'b0, 32'h20, 32'h0, 5'd6, 32'h0);
    @(negedge clk);
    chk("rst_store.readdataM", bus.readdataM, 32'h5555);
    @(posedge clk);
    #1;
    chk("rst_store.resultW", bus.resultW, 32'h5555);
    chk("rst_store.RdW", 32'(bus.RdW), 32'd6);
    chk("rst_store.regwriteW", 32'(bus.regwriteW), 32'd1);

    bubble();
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
